// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, width helpers and parameter sanity check for the sync FIFO
package fifo_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AF = 6;
  localparam int DEF_AE = 2;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = DEF_ADDR_W + 1;
  function automatic bit params_ok(int depth, int af, int ae);
    return depth >= 2 && (depth & (depth - 1)) == 0 && af >= 1 && af <= depth && ae >= 0 && ae < depth;
  endfunction
endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer handshake and status bundle for the sync FIFO
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic [DATA_W-1:0] data_in;
  logic push;
  logic pop;
  logic [DATA_W-1:0] data_out;
  logic valid_out;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [CNT_W-1:0] fill_count;
  logic overflow;
  logic underflow;
  modport master (
    output data_in, push, pop,
    input data_out, valid_out, full, empty, almost_full, almost_empty, fill_count, overflow, underflow
  );
  modport slave (
    input data_in, push, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage, one write port, registered read-before-write read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // read samples the pre-edge contents, so a same-address write is not seen
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= re ? mem[raddr] : '0;
    end
  end
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with pointers, occupancy, flags and error pulses
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF,
  parameter int AE_THRESH = DEF_AE
) (
  input logic clk,
  input logic reset,
  fifo_sync_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("fifo_sync_param: DEPTH must be a power of two >= 2 with thresholds in range");
  end
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic push_ok;
  logic pop_ok;
  assign bus.full = count == CNT_W'(DEPTH);
  assign bus.empty = count == '0;
  assign bus.almost_full = count >= CNT_W'(AF_THRESH);
  assign bus.almost_empty = count <= CNT_W'(AE_THRESH);
  assign bus.fill_count = count;
  // a pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it
  assign push_ok = bus.push & (~bus.full | bus.pop);
  assign pop_ok = bus.pop & ~bus.empty;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.valid_out <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      bus.valid_out <= pop_ok;
      bus.overflow <= bus.push & bus.full & ~bus.pop;
      bus.underflow <= bus.pop & bus.empty;
    end
  end
  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .reset(reset),
    .we(push_ok),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .re(pop_ok),
    .raddr(rd_ptr),
    .rdata(bus.data_out)
  );
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and random stimulus against a queue-based reference FIFO
module tb_fifo_sync_param;
  localparam int DW = 12;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int q[$];
  fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit ps, input bit pp, input int d);
    int e_data, e_valid, e_ovf, e_udf, n;
    bit was_full, was_empty;
    reset = r;
    bus.push = ps;
    bus.pop = pp;
    bus.data_in = DW'(d);
    @(posedge clk);
    e_data = 0;
    e_valid = 0;
    e_ovf = 0;
    e_udf = 0;
    if (!r) q.delete();
    else begin
      was_full = q.size() == DEPTH;
      was_empty = q.size() == 0;
      e_ovf = int'(ps && was_full && !pp);
      e_udf = int'(pp && was_empty);
      if (pp && !was_empty) begin
        e_valid = 1;
        e_data = q.pop_front();
      end
      if (ps && (!was_full || pp)) q.push_back(d & 'hFFF);
    end
    #1;
    n = q.size();
    check("fill_count", int'(bus.fill_count), n);
    check("full", int'(bus.full), int'(n == DEPTH));
    check("empty", int'(bus.empty), int'(n == 0));
    check("almost_full", int'(bus.almost_full), int'(n >= AF));
    check("almost_empty", int'(bus.almost_empty), int'(n <= AE));
    check("data_out", int'(bus.data_out), e_data);
    check("valid_out", int'(bus.valid_out), e_valid);
    check("overflow", int'(bus.overflow), e_ovf);
    check("underflow", int'(bus.underflow), e_udf);
  endtask
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    step(0, 0, 0, 0);
    step(0, 1, 1, 'h123);
    for (int i = 1; i <= 8; i++) step(1, 1, 0, i);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, $urandom_range(0, 4095));
    step(1, 1, 0, 'hABC);
    for (int i = 0; i < 9; i++) step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 'h5A5);
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 'h100 + i);
    step(1, 1, 1, 'h0FF);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, (i % 6) < 3, (i % 6) >= 3, 'h200 + i);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 'h300 + i);
    step(0, 1, 0, 'h3FF);
    step(1, 0, 1, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 60) != 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 4095));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
